// File: rtl/sram_responder.sv
// sram_responder: device-side stand-in for a 256K x 16 asynchronous SRAM.
// Pin writes land on the clock edge, pin reads return one cycle later on
// SRAM_DQ, and a backdoor port plus counters/flags support preload and peek.
module sram_responder #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [15:0]       SRAM_DQ,
    input  logic [17:0]       SRAM_ADDR,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_OE_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    input  logic              bd_en,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [15:0]       bd_wdata,
    output logic [15:0]       bd_rdata,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic              err_oor,
    output logic              err_bd_conflict
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [15:0]       mem [DEPTH];

    logic [ADDR_W-1:0] pinAddr;
    logic              pinOor;
    logic              wrStrobe;
    logic              rdReq;
    logic              wrInRange;
    logic              bdWrite;
    logic              driveEn;
    logic [15:0]       rdData;

    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_oor_q, rd_oor_d;
    logic [15:0]       bdRdata_q, bdRdata_d;
    logic [CNT_W-1:0]  wrCount_q, wrCount_d;
    logic [CNT_W-1:0]  rdCount_q, rdCount_d;
    logic              errOor_q, errOor_d;
    logic              errConflict_q, errConflict_d;

    // Pin decode: the upper address bits beyond the implemented array flag an out-of-range access
    assign pinAddr   = SRAM_ADDR[ADDR_W-1:0];
    assign pinOor    = |SRAM_ADDR[17:ADDR_W];
    assign wrStrobe  = !SRAM_CE_N && !SRAM_WE_N;
    assign rdReq     = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
    assign wrInRange = wrStrobe && !pinOor;
    assign bdWrite   = bd_en && bd_we;

    // Drive only while the current pins still ask for a read, so a switch to write releases the bus at once
    assign driveEn = rd_valid_q && rdReq;

    // Next-state logic for the read pipeline, backdoor read port, counters and sticky flags
    always_comb begin
        rd_valid_d    = rdReq;
        rd_addr_d     = rd_addr_q;
        rd_oor_d      = rd_oor_q;
        bdRdata_d     = bdRdata_q;
        wrCount_d     = wrCount_q;
        rdCount_d     = rdCount_q;
        errOor_d      = errOor_q;
        errConflict_d = errConflict_q;
        rdData        = rd_oor_q ? 16'h0000 : mem[rd_addr_q];

        if (rdReq) begin
            rd_addr_d = pinAddr;
            rd_oor_d  = pinOor;
        end
        if (bd_en && !bd_we) begin
            bdRdata_d = mem[bd_addr];
        end
        if (wrStrobe && (wrCount_q != {CNT_W{1'b1}})) begin
            wrCount_d = wrCount_q + CNT_W'(1);
        end
        if (driveEn && (rdCount_q != {CNT_W{1'b1}})) begin
            rdCount_d = rdCount_q + CNT_W'(1);
        end
        if ((wrStrobe || rdReq) && pinOor) begin
            errOor_d = 1'b1;
        end
        if (bdWrite && wrInRange && (bd_addr == pinAddr)) begin
            errConflict_d = 1'b1;
        end
    end

    // Control state register with synchronous reset; the array itself is deliberately left out
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q    <= 1'b0;
            rd_addr_q     <= '0;
            rd_oor_q      <= 1'b0;
            bdRdata_q     <= 16'h0000;
            wrCount_q     <= '0;
            rdCount_q     <= '0;
            errOor_q      <= 1'b0;
            errConflict_q <= 1'b0;
        end else begin
            rd_valid_q    <= rd_valid_d;
            rd_addr_q     <= rd_addr_d;
            rd_oor_q      <= rd_oor_d;
            bdRdata_q     <= bdRdata_d;
            wrCount_q     <= wrCount_d;
            rdCount_q     <= rdCount_d;
            errOor_q      <= errOor_d;
            errConflict_q <= errConflict_d;
        end
    end

    // Array writes: backdoor first, so a same-word pin write overrides only its enabled lanes
    always_ff @(posedge clk) begin
        if (bdWrite) begin
            mem[bd_addr] <= bd_wdata;
        end
        if (wrInRange) begin
            if (!SRAM_UB_N) begin
                mem[pinAddr][15:8] <= SRAM_DQ[15:8];
            end
            if (!SRAM_LB_N) begin
                mem[pinAddr][7:0] <= SRAM_DQ[7:0];
            end
        end
    end

    // Per-lane tristate drivers follow the byte enables of the current cycle
    assign SRAM_DQ[15:8] = (driveEn && !SRAM_UB_N) ? rdData[15:8] : 8'bz;
    assign SRAM_DQ[7:0]  = (driveEn && !SRAM_LB_N) ? rdData[7:0]  : 8'bz;

    assign bd_rdata        = bdRdata_q;
    assign wr_count        = wrCount_q;
    assign rd_count        = rdCount_q;
    assign err_oor         = errOor_q;
    assign err_bd_conflict = errConflict_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed scenarios for sram_responder with
// hand-computed expectations. Narrow counters make saturation reachable.
module tb_sram_responder;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    wire  [15:0]       SRAM_DQ;
    logic [17:0]       addr;
    logic              weN, oeN, ceN, ubN, lbN;
    logic              bdEn, bdWe;
    logic [ADDR_W-1:0] bdAddr;
    logic [15:0]       bdWdata;
    logic [15:0]       bdRdata;
    logic [CNT_W-1:0]  wrCount, rdCount;
    logic              errOor, errConflict;
    logic [15:0]       tbDq;
    logic              tbDqEn;

    int checkCount = 0;
    int passCount  = 0;

    sram_responder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .SRAM_DQ         (SRAM_DQ),
        .SRAM_ADDR       (addr),
        .SRAM_WE_N       (weN),
        .SRAM_OE_N       (oeN),
        .SRAM_CE_N       (ceN),
        .SRAM_UB_N       (ubN),
        .SRAM_LB_N       (lbN),
        .bd_en           (bdEn),
        .bd_we           (bdWe),
        .bd_addr         (bdAddr),
        .bd_wdata        (bdWdata),
        .bd_rdata        (bdRdata),
        .wr_count        (wrCount),
        .rd_count        (rdCount),
        .err_oor         (errOor),
        .err_bd_conflict (errConflict)
    );

    // The bench acts as the memory controller when it writes
    assign SRAM_DQ = tbDqEn ? tbDq : 16'bz;

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A released lane reads z in a four-state simulator and 0 in a two-state one
    function automatic bit released8(input logic [7:0] v);
        return (v === 8'hzz) || (v === 8'h00);
    endfunction

    // One clock: inputs change at the falling edge, outputs are sampled there too
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Put a full pin-side command on the bus
    task automatic applyStimulus(input logic ce, input logic we, input logic oe,
                                 input logic ub, input logic lb, input logic [17:0] a,
                                 input logic [15:0] d, input logic dEn);
        ceN = ce; weN = we; oeN = oe; ubN = ub; lbN = lb;
        addr = a; tbDq = d; tbDqEn = dEn;
        #1;
    endtask

    task automatic pinIdle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'h0, 16'h0, 1'b0);
    endtask

    task automatic pinWrite(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
        applyStimulus(1'b0, 1'b0, 1'b1, ub, lb, a, d, 1'b1);
    endtask

    task automatic pinRead(input logic [17:0] a, input logic ub, input logic lb);
        applyStimulus(1'b0, 1'b1, 1'b0, ub, lb, a, 16'h0, 1'b0);
    endtask

    task automatic bdWrite(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        bdEn = 1'b1; bdWe = 1'b1; bdAddr = a; bdWdata = d;
        tick();
        bdEn = 1'b0; bdWe = 1'b0;
    endtask

    task automatic bdPeek(input logic [ADDR_W-1:0] a);
        bdEn = 1'b1; bdWe = 1'b0; bdAddr = a;
        tick();
        bdEn = 1'b0;
    endtask

    task automatic doReset();
        pinIdle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pinRead(18'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        checkCount++;
        if (bdRdata !== 16'h0000) $display("[TB] FAIL reset_bd_rdata got %h want 0000", bdRdata);
        else passCount++;
        checkCount++;
        if (wrCount !== 4'd0 || rdCount !== 4'd0)
            $display("[TB] FAIL reset_counts got wr=%0d rd=%0d want 0/0", wrCount, rdCount);
        else passCount++;
        checkCount++;
        if (errOor !== 1'b0 || errConflict !== 1'b0)
            $display("[TB] FAIL reset_flags got oor=%b conf=%b want 0/0", errOor, errConflict);
        else passCount++;
        checkCount++;
        if (!released8(SRAM_DQ[15:8]) || !released8(SRAM_DQ[7:0]))
            $display("[TB] FAIL reset_dq_float got %h want zzzz", SRAM_DQ);
        else passCount++;
        rst = 1'b0;
        pinIdle();
    endtask

    task automatic test_write_read();
        doReset();
        pinWrite(18'h002, 16'h5678, 1'b0, 1'b0);
        tick();
        pinWrite(18'h003, 16'h1234, 1'b0, 1'b0);
        tick();
        pinRead(18'h002, 1'b0, 1'b0);
        tick();
        pinRead(18'h003, 1'b0, 1'b0);
        checkCount++;
        if (SRAM_DQ !== 16'h5678) $display("[TB] FAIL read_0x002 got %h want 5678", SRAM_DQ);
        else passCount++;
        tick();
        checkCount++;
        if (SRAM_DQ !== 16'h1234) $display("[TB] FAIL read_0x003 got %h want 1234", SRAM_DQ);
        else passCount++;
        tick();
        pinIdle();
        tick();
        checkCount++;
        if (wrCount !== 4'd2 || rdCount !== 4'd2)
            $display("[TB] FAIL wr_rd_counts got wr=%0d rd=%0d want 2/2", wrCount, rdCount);
        else passCount++;
    endtask

    task automatic test_read_after_write();
        pinWrite(18'h040, 16'hA5A5, 1'b0, 1'b0);
        tick();
        pinRead(18'h040, 1'b0, 1'b0);
        tick();
        checkCount++;
        if (SRAM_DQ !== 16'hA5A5) $display("[TB] FAIL raw_0x040 got %h want a5a5", SRAM_DQ);
        else passCount++;
        pinIdle();
        tick();
    endtask

    task automatic test_byte_lanes();
        doReset();
        bdWrite(10'h010, 16'hAAAA);
        pinWrite(18'h010, 16'h1234, 1'b1, 1'b0);
        tick();
        pinIdle();
        bdPeek(10'h010);
        checkCount++;
        if (bdRdata !== 16'hAA34) $display("[TB] FAIL lane_peek got %h want aa34", bdRdata);
        else passCount++;
        pinRead(18'h010, 1'b0, 1'b1);
        tick();
        checkCount++;
        if (SRAM_DQ[15:8] !== 8'hAA) $display("[TB] FAIL lane_read_upper got %h want aa", SRAM_DQ[15:8]);
        else passCount++;
        checkCount++;
        if (!released8(SRAM_DQ[7:0])) $display("[TB] FAIL lane_read_lower got %h want zz", SRAM_DQ[7:0]);
        else passCount++;
        pinIdle();
        tick();
    endtask

    task automatic test_turnaround();
        doReset();
        bdWrite(10'h020, 16'h1111);
        pinRead(18'h020, 1'b0, 1'b0);
        tick();
        pinWrite(18'h021, 16'hBEEF, 1'b0, 1'b0);
        tbDqEn = 1'b0;
        #1;
        checkCount++;
        if (!released8(SRAM_DQ[15:8]) || !released8(SRAM_DQ[7:0]))
            $display("[TB] FAIL turn_release got %h want zzzz", SRAM_DQ);
        else passCount++;
        tbDqEn = 1'b1;
        #1;
        checkCount++;
        if (SRAM_DQ !== 16'hBEEF) $display("[TB] FAIL turn_bus got %h want beef", SRAM_DQ);
        else passCount++;
        tick();
        pinIdle();
        bdPeek(10'h021);
        checkCount++;
        if (bdRdata !== 16'hBEEF || rdCount !== 4'd0)
            $display("[TB] FAIL turn_write got data=%h rd=%0d want beef/0", bdRdata, rdCount);
        else passCount++;
    endtask

    task automatic test_out_of_range();
        doReset();
        bdWrite(10'h000, 16'h0C0C);
        pinWrite(18'h00400, 16'h1234, 1'b0, 1'b0);
        tick();
        checkCount++;
        if (errOor !== 1'b1 || wrCount !== 4'd1)
            $display("[TB] FAIL oor_write got oor=%b wr=%0d want 1/1", errOor, wrCount);
        else passCount++;
        pinRead(18'h00400, 1'b0, 1'b0);
        tick();
        checkCount++;
        if (SRAM_DQ !== 16'h0000) $display("[TB] FAIL oor_read got %h want 0000", SRAM_DQ);
        else passCount++;
        tick();
        pinIdle();
        bdPeek(10'h000);
        checkCount++;
        if (bdRdata !== 16'h0C0C || rdCount !== 4'd1)
            $display("[TB] FAIL oor_peek got data=%h rd=%0d want 0c0c/1", bdRdata, rdCount);
        else passCount++;
    endtask

    task automatic test_conflict();
        doReset();
        bdEn = 1'b1; bdWe = 1'b1; bdAddr = 10'h005; bdWdata = 16'hFFFF;
        pinWrite(18'h005, 16'h0001, 1'b0, 1'b0);
        tick();
        bdAddr = 10'h006;
        pinWrite(18'h006, 16'h0001, 1'b1, 1'b0);
        tick();
        bdEn = 1'b0; bdWe = 1'b0;
        pinIdle();
        checkCount++;
        if (errConflict !== 1'b1 || errOor !== 1'b0)
            $display("[TB] FAIL conflict_flag got conf=%b oor=%b want 1/0", errConflict, errOor);
        else passCount++;
        bdPeek(10'h005);
        checkCount++;
        if (bdRdata !== 16'h0001) $display("[TB] FAIL conflict_full got %h want 0001", bdRdata);
        else passCount++;
        bdPeek(10'h006);
        checkCount++;
        if (bdRdata !== 16'hFF01) $display("[TB] FAIL conflict_lane got %h want ff01", bdRdata);
        else passCount++;
    endtask

    task automatic test_reset_mid_read();
        doReset();
        pinWrite(18'h030, 16'hCAFE, 1'b0, 1'b0);
        tick();
        pinWrite(18'h3FFFF, 16'h0000, 1'b0, 1'b0);
        tick();
        pinRead(18'h030, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        checkCount++;
        if (!released8(SRAM_DQ[15:8]) || !released8(SRAM_DQ[7:0]))
            $display("[TB] FAIL rst_dq_float got %h want zzzz", SRAM_DQ);
        else passCount++;
        checkCount++;
        if (wrCount !== 4'd0 || rdCount !== 4'd0 || errOor !== 1'b0 || errConflict !== 1'b0)
            $display("[TB] FAIL rst_clear got wr=%0d rd=%0d oor=%b conf=%b want 0/0/0/0",
                     wrCount, rdCount, errOor, errConflict);
        else passCount++;
        rst = 1'b0;
        tick();
        checkCount++;
        if (SRAM_DQ !== 16'hCAFE) $display("[TB] FAIL rst_data_kept got %h want cafe", SRAM_DQ);
        else passCount++;
        pinIdle();
        tick();
    endtask

    task automatic test_saturation();
        doReset();
        bdWrite(10'h050, 16'h1357);
        pinWrite(18'h050, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 18; i++) tick();
        pinIdle();
        checkCount++;
        if (wrCount !== 4'hF) $display("[TB] FAIL wr_saturate got %0d want 15", wrCount);
        else passCount++;
        bdPeek(10'h050);
        checkCount++;
        if (bdRdata !== 16'h1357) $display("[TB] FAIL no_lane_write got %h want 1357", bdRdata);
        else passCount++;
    endtask

    // Scenario sequence
    initial begin
        rst = 1'b1;
        bdEn = 1'b0; bdWe = 1'b0; bdAddr = '0; bdWdata = 16'h0;
        ceN = 1'b1; weN = 1'b1; oeN = 1'b1; ubN = 1'b0; lbN = 1'b0;
        addr = 18'h0; tbDq = 16'h0; tbDqEn = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_read_after_write();
        test_byte_lanes();
        test_turnaround();
        test_out_of_range();
        test_conflict();
        test_reset_mid_read();
        test_saturation();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
